key_matrix_scanner: RTL and testbench

Scans a 4×4 active-low switch matrix on the iceFUN board, debounces all 16 keys and emits press/release events through a small FIFO with a valid/ready handshake. It drives the matrix in the opposite direction to the LED driver: it drives column strobes and reads row returns instead of driving row data. Consumers take either the debounced level vector `keys` or the event stream.

---
 rtl/key_matrix_scanner.sv | 155 +++++++++++++++
 tb/tb_key_matrix_scanner.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/key_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module      : key_matrix_scanner
// Description : Scans a 4x4 active-low key matrix. It drives column strobes,
//               synchronises the row returns and debounces each key. Press and
//               release events are queued in a small FIFO that the consumer
//               reads with a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module key_matrix_scanner #(
    parameter int SCAN_BITS  = 10,   // column dwell = 2^SCAN_BITS clocks, >= 3
    parameter int DEBOUNCE   = 4,    // differing frames to flip a key, 1..15
    parameter int FIFO_DEPTH = 4     // event FIFO entries, power of two, >= 2
) (
    input  logic        clk12MHz,
    input  logic        resetn,
    input  logic        krow1,
    input  logic        krow2,
    input  logic        krow3,
    input  logic        krow4,
    output logic        kcol1,
    output logic        kcol2,
    output logic        kcol3,
    output logic        kcol4,
    output logic [15:0] keys,
    output logic        event_valid,
    output logic [3:0]  event_key,
    output logic        event_pressed,
    input  logic        event_ready,
    output logic        overflow
);

    localparam int         c_AW  = $clog2(FIFO_DEPTH);
    localparam logic [3:0] c_DEB = 4'(DEBOUNCE);

    // ------------------------------------------------------------------------
    // Row synchronisers (rows idle high, so reset to released)
    // ------------------------------------------------------------------------
    logic [3:0] r_row_meta;
    logic [3:0] r_row_sync;

    // Two-flop synchroniser on the asynchronous row returns
    always_ff @(posedge clk12MHz) begin
        if (!resetn) begin
            r_row_meta <= 4'hF;
            r_row_sync <= 4'hF;
        end else begin
            r_row_meta <= {krow4, krow3, krow2, krow1};
            r_row_sync <= r_row_meta;
        end
    end

    // ------------------------------------------------------------------------
    // Scan counter: upper two bits select the column, lower bits the dwell
    // ------------------------------------------------------------------------
    logic [SCAN_BITS+1:0] r_scan;
    logic [1:0]           w_col;
    logic [SCAN_BITS-1:0] w_dwell;
    logic                 w_proc;
    logic [1:0]           w_row;
    logic [3:0]           w_key;
    logic                 w_sample;

    // Free-running scan counter; wraps from column 3 back to column 0
    always_ff @(posedge clk12MHz) begin
        if (!resetn) r_scan <= '0;
        else         r_scan <= r_scan + 1'b1;
    end

    assign w_col   = r_scan[SCAN_BITS+1:SCAN_BITS];
    assign w_dwell = r_scan[SCAN_BITS-1:0];
    // The last four dwell cycles of each column evaluate rows 1..4 in turn,
    // so the column has been driven long enough for the returns to settle.
    assign w_proc   = &w_dwell[SCAN_BITS-1:2];
    assign w_row    = w_dwell[1:0];
    assign w_key    = {w_col, w_row};
    assign w_sample = ~r_row_sync[w_row];

    assign {kcol4, kcol3, kcol2, kcol1} = ~(4'b0001 << w_col);

    // ------------------------------------------------------------------------
    // Per-key debounce: one key evaluated per process cycle
    // ------------------------------------------------------------------------
    logic [15:0] r_keys;
    logic [3:0]  r_dcnt [16];
    logic [3:0]  w_cnt_inc;
    logic        w_differ;
    logic        w_flip;

    assign w_cnt_inc = 4'(r_dcnt[w_key] + 4'd1);
    assign w_differ  = (w_sample != r_keys[w_key]);
    assign w_flip    = w_proc && w_differ && (w_cnt_inc == c_DEB);

    // Count consecutive differing frames; toggle the stable state at threshold
    always_ff @(posedge clk12MHz) begin
        if (!resetn) begin
            r_keys <= '0;
            for (int i = 0; i < 16; i++) r_dcnt[i] <= '0;
        end else if (w_proc) begin
            if (!w_differ) begin
                r_dcnt[w_key] <= '0;
            end else if (w_flip) begin
                r_keys[w_key] <= ~r_keys[w_key];
                r_dcnt[w_key] <= '0;
            end else begin
                r_dcnt[w_key] <= w_cnt_inc;
            end
        end
    end

    assign keys = r_keys;

    // ------------------------------------------------------------------------
    // Event FIFO: {key, pressed}; pointers carry one extra wrap bit
    // ------------------------------------------------------------------------
    logic [4:0]  r_mem [FIFO_DEPTH];
    logic [c_AW:0] r_wptr;
    logic [c_AW:0] r_rptr;
    logic        r_overflow;
    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_accept;

    assign w_empty  = (r_wptr == r_rptr);
    assign w_full   = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                      (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
    assign w_pop    = !w_empty && event_ready;
    // A simultaneous pop frees the slot, so a push into a full FIFO survives.
    assign w_accept = w_flip && (!w_full || w_pop);

    // Event storage; the new state is the inverse of the current stable bit
    always_ff @(posedge clk12MHz) begin
        if (w_accept) r_mem[r_wptr[c_AW-1:0]] <= {w_key, ~r_keys[w_key]};
    end

    // FIFO pointers and sticky overflow flag
    always_ff @(posedge clk12MHz) begin
        if (!resetn) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) r_wptr <= r_wptr + 1'b1;
            if (w_pop)    r_rptr <= r_rptr + 1'b1;
            if (w_flip && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    assign event_valid                = !w_empty;
    assign {event_key, event_pressed} = r_mem[r_rptr[c_AW-1:0]];
    assign overflow                   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_key_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_matrix_scanner
// Description : Directed self-checking bench for key_matrix_scanner with a
//               behavioural switch matrix (SCAN_BITS=3: 8-clock dwell,
//               32-clock frame; DEBOUNCE=4; FIFO_DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_matrix_scanner;

    logic        clk = 1'b0;
    logic        resetn;
    logic        krow1, krow2, krow3, krow4;
    logic        kcol1, kcol2, kcol3, kcol4;
    logic [15:0] keys;
    logic        event_valid;
    logic [3:0]  event_key;
    logic        event_pressed;
    logic        event_ready;
    logic        overflow;

    logic [15:0] r_press;      // which switches are physically closed
    int          n_checks = 0;
    int          n_fail   = 0;
    int          t;            // negedges since the last reset release

    key_matrix_scanner #(
        .SCAN_BITS (3),
        .DEBOUNCE  (4),
        .FIFO_DEPTH(4)
    ) u_dut (
        .clk12MHz     (clk),
        .resetn       (resetn),
        .krow1        (krow1),
        .krow2        (krow2),
        .krow3        (krow3),
        .krow4        (krow4),
        .kcol1        (kcol1),
        .kcol2        (kcol2),
        .kcol3        (kcol3),
        .kcol4        (kcol4),
        .keys         (keys),
        .event_valid  (event_valid),
        .event_key    (event_key),
        .event_pressed(event_pressed),
        .event_ready  (event_ready),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    // Switch matrix: a closed switch pulls its row low while its column is low
    logic [3:0] w_kcol;
    logic [3:0] w_rows;
    assign w_kcol = {kcol4, kcol3, kcol2, kcol1};
    always_comb begin
        w_rows = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!w_kcol[c] && r_press[c*4+r]) w_rows[r] = 1'b0;
    end
    assign {krow4, krow3, krow2, krow1} = w_rows;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic head(input string tag, input logic [3:0] k, input logic p);
        check({tag, "_valid"},   16'(event_valid),   16'h1);
        check({tag, "_key"},     16'(event_key),     16'(k));
        check({tag, "_pressed"}, 16'(event_pressed), 16'(p));
    endtask

    task automatic step_to(input int target);
        while (t < target) begin
            @(negedge clk);
            t++;
        end
    endtask

    initial begin
        resetn      = 1'b0;
        r_press     = '0;
        event_ready = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        t      = 0;

        // Reset state
        check("rst_kcol",  16'(w_kcol),      16'h000E);
        check("rst_keys",  keys,             16'h0000);
        check("rst_valid", 16'(event_valid), 16'h0);
        check("rst_ovf",   16'(overflow),    16'h0);

        // Press key 9: evaluated at 32f+21, fourth decision visible at t=118
        r_press[9] = 1'b1;
        step_to(117);
        check("press9_early", keys, 16'h0000);
        check("press9_early_valid", 16'(event_valid), 16'h0);
        step_to(118);
        check("press9_keys", keys, 16'h0200);
        head("press9", 4'd9, 1'b1);
        event_ready = 1'b1;
        step_to(119);
        event_ready = 1'b0;
        check("press9_popped", 16'(event_valid), 16'h0);
        step_to(192);
        check("press9_held_keys",  keys, 16'h0200);
        check("press9_held_valid", 16'(event_valid), 16'h0);

        // Release key 9: frames 6..9, decision visible at 9*32+22 = 310
        r_press[9] = 1'b0;
        step_to(309);
        check("rel9_early", keys, 16'h0200);
        step_to(310);
        check("rel9_keys", keys, 16'h0000);
        head("rel9", 4'd9, 1'b0);
        event_ready = 1'b1;
        step_to(311);
        event_ready = 1'b0;
        check("rel9_popped", 16'(event_valid), 16'h0);

        // Bounce on key 2: 3 frames closed, 1 frame open, twice
        step_to(320);
        for (int rep = 0; rep < 2; rep++) begin
            r_press[2] = 1'b1;
            step_to(t + 96);
            r_press[2] = 1'b0;
            step_to(t + 32);
        end
        check("bounce_keys",  keys, 16'h0000);
        check("bounce_valid", 16'(event_valid), 16'h0);

        // Whole column 1: decisions at 685..688 on consecutive clocks
        r_press[7:4] = 4'hF;
        step_to(684);
        check("col1_early_valid", 16'(event_valid), 16'h0);
        step_to(685);
        head("col1_first", 4'd4, 1'b1);
        step_to(689);
        check("col1_keys", keys, 16'h00F0);
        head("col1_pop4", 4'd4, 1'b1);
        event_ready = 1'b1;
        step_to(690);
        head("col1_pop5", 4'd5, 1'b1);
        step_to(691);
        head("col1_pop6", 4'd6, 1'b1);
        step_to(692);
        head("col1_pop7", 4'd7, 1'b1);
        step_to(693);
        event_ready = 1'b0;
        check("col1_drained", 16'(event_valid), 16'h0);

        // Overflow: keys 0..3 (visible 805..808) then key 8 (821) is dropped
        step_to(704);
        r_press[3:0] = 4'hF;
        r_press[8]   = 1'b1;
        step_to(820);
        check("ovf_before", 16'(overflow), 16'h0);
        step_to(821);
        check("ovf_set",  16'(overflow), 16'h1);
        check("ovf_keys", keys, 16'h01FF);
        head("ovf_pop0", 4'd0, 1'b1);
        event_ready = 1'b1;
        step_to(822);
        head("ovf_pop1", 4'd1, 1'b1);
        step_to(823);
        head("ovf_pop2", 4'd2, 1'b1);
        step_to(824);
        head("ovf_pop3", 4'd3, 1'b1);
        step_to(825);
        event_ready = 1'b0;
        check("ovf_drained", 16'(event_valid), 16'h0);
        check("ovf_sticky",  16'(overflow),    16'h1);

        // Queue releases of keys 4,5 (visible 941,942), then reset one clock
        step_to(832);
        r_press[5:4] = 2'b00;
        step_to(943);
        check("pre_rst_keys", keys, 16'h01CF);
        head("pre_rst_head", 4'd4, 1'b0);
        step_to(944);
        r_press = 16'h0001;
        resetn  = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        t      = 0;
        check("mid_rst_valid", 16'(event_valid), 16'h0);
        check("mid_rst_keys",  keys,             16'h0000);
        check("mid_rst_kcol",  16'(w_kcol),      16'h000E);
        check("mid_rst_ovf",   16'(overflow),    16'h0);

        // Key 0 held through reset: evaluated at 32f+4, visible at t=101
        step_to(100);
        check("rekey0_early", keys, 16'h0000);
        check("rekey0_early_valid", 16'(event_valid), 16'h0);
        step_to(101);
        check("rekey0_keys", keys, 16'h0001);
        head("rekey0", 4'd0, 1'b1);
        event_ready = 1'b1;
        step_to(102);
        event_ready = 1'b0;
        check("rekey0_popped", 16'(event_valid), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
